// File: rtl/datamem_fill.sv
// datamem_fill: single-port data memory for the load/store stage with a
// req/ready access port, a configurable-latency read pipeline (rvalid
// strobe) and a block-fill engine that writes one value across an
// address range.
//
// Handshake: an access is accepted on a rising edge where req && ready.
// ready is combinational and drops while a fill runs, on the cycle a fill
// is launched, and during reset. The core holds req, we, addr and data_in
// stable until it sees the accept. Read results return on rvalid RD_LAT
// cycles after acceptance, in order, one per accepted read.
module datamem_fill #(
  parameter int DW     = 8,
  parameter int AW     = 8,
  parameter int RD_LAT = 1   // legal range 1..4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_in,
  output logic          ready,
  output logic          rvalid,
  output logic [DW-1:0] data_out,
  input  logic          fill_start,
  input  logic [AW-1:0] fill_base,
  input  logic [AW:0]   fill_len,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  output logic          fsm_state   // debug view of the fill FSM: 0 = IDLE, 1 = FILL
);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t state, state_next;

  // Fill parameters captured on the start cycle, plus the write counter.
  logic [AW-1:0] base_q;
  logic [AW:0]   len_q;
  logic [AW:0]   cnt_q;
  logic [DW-1:0] val_q;
  logic          done_q;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  logic [RD_LAT-1:0] vld_q;
  logic [DW-1:0]     dat_q [RD_LAT];

  logic          start_fill;
  logic          start_empty;
  logic          last_write;
  logic          wr_acc;
  logic          rd_acc;
  logic [AW-1:0] fill_addr;

  assign start_fill  = (state == IDLE) && fill_start && (fill_len != '0);
  assign start_empty = (state == IDLE) && fill_start && (fill_len == '0);
  assign last_write  = (state == FILL) && (cnt_q == (len_q - 1'b1));
  assign wr_acc      = req && ready && we;
  assign rd_acc      = req && ready && !we;
  assign fill_addr   = base_q + cnt_q[AW-1:0];   // wraps modulo 2**AW

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        ready = !fill_start && !reset;
        if (start_fill) state_next = FILL;
      end
      FILL: begin
        busy = 1'b1;
        if (last_write) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Fill parameter capture, write counter and completion strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      val_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= start_empty || last_write;
      if (start_fill) begin
        base_q <= fill_base;
        len_q  <= fill_len;
        val_q  <= fill_val;
        cnt_q  <= '0;
      end else if (state == FILL) begin
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  // Memory array: contents survive reset; fill and core writes never coincide.
  always_ff @(posedge clock) begin
    if (state == FILL)  mem[fill_addr] <= val_q;
    else if (wr_acc)    mem[addr]      <= data_in;
  end

  // Read pipeline: data is captured at accept, so later writes cannot alter
  // it; each stage only advances with a valid entry so data_out holds.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int k = 0; k < RD_LAT; k++) dat_q[k] <= '0;
    end else begin
      vld_q[0] <= rd_acc;
      if (rd_acc) dat_q[0] <= mem[addr];
      for (int k = 1; k < RD_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
      end
    end
  end

  assign rvalid    = vld_q[RD_LAT-1];
  assign data_out  = dat_q[RD_LAT-1];
  assign done      = done_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_datamem_fill.sv
// tb_datamem_fill: drives identical stimulus into an RD_LAT=1 and an
// RD_LAT=3 instance and compares both against a cycle-scheduled model
// (memory array, fill schedule by cycle number, per-latency read queues).
module tb_datamem_fill;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       req, we, fill_start;
  logic [7:0] addr, data_in, fill_base, fill_val;
  logic [8:0] fill_len;

  logic       ready1, rvalid1, busy1, done1, st1;
  logic [7:0] data_out1;
  logic       ready3, rvalid3, busy3, done3, st3;
  logic [7:0] data_out3;

  datamem_fill #(.DW(8), .AW(8), .RD_LAT(1)) u1 (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr),
    .data_in(data_in), .ready(ready1), .rvalid(rvalid1), .data_out(data_out1),
    .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
    .fill_val(fill_val), .busy(busy1), .done(done1), .fsm_state(st1)
  );

  datamem_fill #(.DW(8), .AW(8), .RD_LAT(3)) u3 (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr),
    .data_in(data_in), .ready(ready3), .rvalid(rvalid3), .data_out(data_out3),
    .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
    .fill_val(fill_val), .busy(busy3), .done(done3), .fsm_state(st3)
  );

  // ---------------- reference model ----------------
  logic [7:0] mmem [256];
  int         cyc;
  int         f_first, f_last, f_idx, done_at;
  logic [7:0] f_base_m, f_val_m;
  int         due1_q[$];
  logic [7:0] exp_q1[$];
  int         due3_q[$];
  logic [7:0] exp_q3[$];
  logic [7:0] last1, last3;

  int n_checks, n_errors;
  int busy_seen, done_seen;

  function automatic bit m_busy(input int c);
    return (c >= f_first) && (c <= f_last);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    f_first = -1; f_last = -2; f_idx = 0; done_at = -1;
    due1_q.delete(); exp_q1.delete();
    due3_q.delete(); exp_q3.delete();
    last1 = 8'h00; last3 = 8'h00;
  endtask

  // Compare registered outputs shortly after an edge.
  task automatic post_edge_checks();
    bit eb, ed, ev1, ev3;
    eb = m_busy(cyc);
    ed = (cyc == done_at);
    check("busy_l1", busy1, eb);
    check("busy_l3", busy3, eb);
    check("done_l1", done1, ed);
    check("done_l3", done3, ed);
    ev1 = (due1_q.size() > 0) && (due1_q[0] == cyc);
    if (ev1) begin last1 = exp_q1.pop_front(); void'(due1_q.pop_front()); end
    ev3 = (due3_q.size() > 0) && (due3_q[0] == cyc);
    if (ev3) begin last3 = exp_q3.pop_front(); void'(due3_q.pop_front()); end
    check("rvalid_l1", rvalid1, ev1);
    check("data_l1", data_out1, last1);
    check("rvalid_l3", rvalid3, ev3);
    check("data_l3", data_out3, last3);
    busy_seen += int'(busy1);
    done_seen += int'(done1);
  endtask

  // ---------------- driver ----------------
  // One clock cycle: apply inputs, check ready, advance the model across
  // the edge, then check the registered outputs.
  task automatic tick(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d,
                      input logic fs, input logic [7:0] fb, input logic [8:0] fl,
                      input logic [7:0] fv, input bit use_exp = 1'b0,
                      input logic [7:0] exp_rd = 8'h00);
    bit         er;
    logic [7:0] wa, rd;
    req = r; we = w; addr = a; data_in = d;
    fill_start = fs; fill_base = fb; fill_len = fl; fill_val = fv;
    #1;
    er = !m_busy(cyc) && !fs;
    check("ready_l1", ready1, er);
    check("ready_l3", ready3, er);
    if (m_busy(cyc)) begin
      wa = f_base_m + 8'(f_idx);
      mmem[wa] = f_val_m;
      f_idx++;
    end else if (fs) begin
      if (fl == 9'd0) begin
        done_at = cyc + 1;
      end else begin
        f_first = cyc + 1; f_last = cyc + int'(fl);
        f_base_m = fb; f_val_m = fv; f_idx = 0;
        done_at = cyc + int'(fl) + 1;
      end
    end else if (r) begin
      if (w) begin
        mmem[a] = d;
      end else begin
        rd = use_exp ? exp_rd : mmem[a];
        due1_q.push_back(cyc + 1); exp_q1.push_back(rd);
        due3_q.push_back(cyc + 3); exp_q3.push_back(rd);
      end
    end
    @(posedge clock); #1;
    cyc++;
    post_edge_checks();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 8'h00, 8'h00, 0, 8'h00, 9'd0, 8'h00);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    tick(1, 1, a, d, 0, 8'h00, 9'd0, 8'h00);
  endtask

  task automatic rd_exp(input logic [7:0] a, input logic [7:0] e);
    tick(1, 0, a, 8'h00, 0, 8'h00, 9'd0, 8'h00, 1'b1, e);
  endtask

  // Reset asserted mid-cycle: outputs must drop without waiting for an edge.
  task automatic do_reset_mid();
    req = 0; fill_start = 0;
    #2 reset = 1'b1;
    #1;
    check("rst_busy_l1", busy1, 1'b0);
    check("rst_busy_l3", busy3, 1'b0);
    check("rst_done_l1", done1, 1'b0);
    check("rst_rvalid_l1", rvalid1, 1'b0);
    check("rst_rvalid_l3", rvalid3, 1'b0);
    check("rst_ready_l1", ready1, 1'b0);
    check("rst_ready_l3", ready3, 1'b0);
    model_clear();
    @(posedge clock); #1;
    cyc++;
    post_edge_checks();
    #3 reset = 1'b0;
    #1;
    check("rel_ready_l1", ready1, 1'b1);
    check("rel_ready_l3", ready3, 1'b1);
    @(posedge clock); #1;
    cyc++;
    post_edge_checks();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[14];

  initial begin
    req = 0; we = 0; addr = 0; data_in = 0;
    fill_start = 0; fill_base = 0; fill_len = 0; fill_val = 0;
    n_checks = 0; n_errors = 0; busy_seen = 0; done_seen = 0;
    cyc = 0;
    for (int i = 0; i < 256; i++) mmem[i] = 8'h00;
    model_clear();

    vt[0]  = '{1'b1, 8'h10, 8'hA5, 8'h00};
    vt[1]  = '{1'b0, 8'h10, 8'h00, 8'hA5};
    vt[2]  = '{1'b1, 8'h00, 8'h11, 8'h00};
    vt[3]  = '{1'b1, 8'h01, 8'h22, 8'h00};
    vt[4]  = '{1'b1, 8'h02, 8'h33, 8'h00};
    vt[5]  = '{1'b1, 8'h03, 8'h44, 8'h00};
    vt[6]  = '{1'b0, 8'h00, 8'h00, 8'h11};
    vt[7]  = '{1'b0, 8'h01, 8'h00, 8'h22};
    vt[8]  = '{1'b0, 8'h02, 8'h00, 8'h33};
    vt[9]  = '{1'b0, 8'h03, 8'h00, 8'h44};
    vt[10] = '{1'b1, 8'h20, 8'h5A, 8'h00};
    vt[11] = '{1'b1, 8'h20, 8'hC3, 8'h00};
    vt[12] = '{1'b0, 8'h20, 8'h00, 8'hC3};
    vt[13] = '{1'b0, 8'h10, 8'h00, 8'hA5};

    // Reset state (data_out is 0, nothing strobing, not ready).
    #1;
    check("init_ready_l1", ready1, 1'b0);
    check("init_busy_l1", busy1, 1'b0);
    check("init_done_l3", done3, 1'b0);
    check("init_rvalid_l1", rvalid1, 1'b0);
    check("init_rvalid_l3", rvalid3, 1'b0);
    check("init_data_l1", data_out1, 8'h00);
    check("init_data_l3", data_out3, 8'h00);
    @(posedge clock); #1;
    #2 reset = 1'b0;
    @(posedge clock); #1;
    cyc = 0;

    // Table-driven core accesses, back-to-back.
    for (int i = 0; i < 14; i++) begin
      if (vt[i].we) wr(vt[i].addr, vt[i].data);
      else          rd_exp(vt[i].addr, vt[i].exp);
    end
    idle_n(4);

    // Wrapping fill FE..01 with a read in flight across the fill start.
    wr(8'hFE, 8'h99); wr(8'hFF, 8'h99); wr(8'h00, 8'h99); wr(8'h01, 8'h99);
    wr(8'h02, 8'h3C);
    rd_exp(8'h10, 8'hA5);
    busy_seen = 0; done_seen = 0;
    tick(0, 0, 8'h00, 8'h00, 1, 8'hFE, 9'd4, 8'h5A);
    idle_n(6);
    check("fill4_busy_cycles", busy_seen, 4);
    check("fill4_done_pulses", done_seen, 1);
    rd_exp(8'hFE, 8'h5A); rd_exp(8'hFF, 8'h5A);
    rd_exp(8'h00, 8'h5A); rd_exp(8'h01, 8'h5A);
    rd_exp(8'h02, 8'h3C);
    idle_n(4);

    // fill_start beats a simultaneous write; the held write lands afterwards.
    tick(1, 1, 8'h20, 8'h77, 1, 8'h20, 9'd1, 8'h00);
    tick(1, 1, 8'h20, 8'h77, 0, 8'h00, 9'd0, 8'h00);
    tick(1, 1, 8'h20, 8'h77, 0, 8'h00, 9'd0, 8'h00);
    rd_exp(8'h20, 8'h77);
    idle_n(4);

    // Full-depth fill wrapping from a non-zero base.
    busy_seen = 0; done_seen = 0;
    tick(0, 0, 8'h00, 8'h00, 1, 8'h37, 9'd256, 8'hFF);
    idle_n(258);
    check("fill256_busy_cycles", busy_seen, 256);
    check("fill256_done_pulses", done_seen, 1);
    for (int i = 0; i < 256; i++) rd_exp(8'(i), 8'hFF);
    idle_n(4);

    // Zero-length fill: done next cycle, no busy, no writes.
    wr(8'h50, 8'h12);
    busy_seen = 0; done_seen = 0;
    tick(0, 0, 8'h00, 8'h00, 1, 8'h50, 9'd0, 8'h00);
    idle_n(3);
    check("fill0_busy_cycles", busy_seen, 0);
    check("fill0_done_pulses", done_seen, 1);
    rd_exp(8'h50, 8'h12);
    idle_n(4);

    // Reset three words into a ten-word fill.
    for (int i = 0; i < 10; i++) wr(8'h40 + 8'(i), 8'h60 + 8'(i));
    tick(0, 0, 8'h00, 8'h00, 1, 8'h40, 9'd10, 8'hEE);
    idle_n(3);
    done_seen = 0;
    do_reset_mid();
    idle_n(12);
    check("abort_no_done", done_seen, 0);
    for (int i = 0; i < 10; i++) rd_exp(8'h40 + 8'(i), (i < 3) ? 8'hEE : 8'h60 + 8'(i));
    idle_n(4);

    // Reset with a read still in the pipeline: it must never return.
    rd_exp(8'h40, 8'hEE);
    idle_n(1);
    do_reset_mid();
    idle_n(5);

    // Randomized traffic, including fill_start during a fill and
    // fill inputs changing while a fill runs.
    for (int i = 0; i < 600; i++) begin
      logic       r, w, fs;
      logic [7:0] a, d, fb, fv;
      logic [8:0] fl;
      r  = ($urandom_range(0, 3) != 0);
      w  = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 31));
      d  = 8'($urandom);
      fs = ($urandom_range(0, 15) == 0);
      fb = 8'($urandom_range(0, 31));
      fl = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 3)) : 9'($urandom_range(4, 24));
      fv = 8'($urandom);
      tick(r, w, a, d, fs, fb, fl, fv);
    end
    idle_n(30);
    for (int i = 0; i < 32; i++) tick(1, 0, 8'(i), 8'h00, 0, 8'h00, 9'd0, 8'h00);
    idle_n(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/datamem_fill.md
# datamem_fill

Parametrised successor to the processor's 8-bit data memory. Adds a request/ready handshake, a configurable registered read latency with an `rvalid` strobe, and a hardware block-fill engine. The fill engine writes one constant value across an address range, which software uses for array clearing and initialisation. The block sits between the core's load/store stage and nothing else: it is the single data-memory instance.

## Interface
- `DW`, 8, data width in bits.
- `AW`, 8, address width; depth is 2**AW words.
- `RD_LAT`, 1, read latency in cycles; legal range 1..4.

- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high. Clears control state only; memory contents are not reset.
- `req`  in  1  core access request.
- `we`  in  1  with `req`: 1 = write, 0 = read.
- `addr`  in  AW  access address.
- `data_in`  in  DW  write data.
- `ready`  out  1  access accepted this cycle when `req && ready`.
- `rvalid`  out  1  one-cycle strobe; `data_out` is valid.
- `data_out`  out  DW  read data; holds its last value when `rvalid` is 0.
- `fill_start`  in  1  one-cycle pulse that launches a block fill.
- `fill_base`  in  AW  first fill address.
- `fill_len`  in  AW+1  number of words to fill, 0..2**AW.
- `fill_val`  in  DW  value written by the fill.
- `busy`  out  1  fill in progress.
- `done`  out  1  one-cycle strobe at fill completion.

## Operation
- States are IDLE and FILL. Reset forces IDLE.
- `ready` = (state == IDLE) && !`fill_start` && !`reset`. It is combinational, so `fill_start` beats a simultaneous `req`: that request is not accepted and the core must hold it.
- Write accept (`req && we && ready`): `mem[addr] <= data_in` at that edge.
- Read accept (`req && !we && ready`): `mem[addr]` is sampled at the accept edge into an RD_LAT-deep valid/data pipeline. A later write or fill to the same address does not change data already in flight.
- Reads and writes can be accepted back-to-back, one per cycle, with no bubbles.
- In IDLE, `fill_start` with `fill_len` > 0:
  - latch base, length and value;
  - go to FILL with `busy` = 1;
  - write counter `i` = 0.
- In FILL, each cycle writes `fill_val` to `(fill_base + i) mod 2**AW` and increments `i`.
- After the write with `i == fill_len-1`: return to IDLE, `busy` = 0, and `done` pulses 1 in the cycle after that last write.
- `fill_len == 2**AW` writes every location exactly once; the address wraps past 2**AW-1 to 0.
- `fill_start` with `fill_len == 0`: no writes, `busy` stays 0, `done` pulses on the next cycle.
- `fill_start` while in FILL is ignored.
- Fill inputs are sampled only on the start cycle; later changes have no effect.
- Reset mid-fill: abort immediately. Locations already written keep their new values; the rest are unchanged. The read pipeline is flushed, and no `rvalid` or `done` is produced for the aborted work.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `rvalid` 0 (all pipeline stages), `data_out` 0, fill counter 0. `ready` is 0 while `reset` is high and 1 after release.
- Read accepted at edge N gives `rvalid` = 1 and valid `data_out` in the cycle after edge N+RD_LAT-1. With RD_LAT = 1 that is the cycle immediately after the accept.
- A write accepted at edge N is visible to a read accepted at edge N+1.
- A fill of L words with `fill_start` sampled at edge N:
  - writes occur at edges N+1 .. N+L;
  - `busy` is high for cycles N+1 .. N+L;
  - `done` is high in cycle N+L+1;
  - `ready` returns to 1 in cycle N+L+1.
- Reads accepted before the fill still deliver `rvalid` during FILL.

## Test plan
- Reset release, RD_LAT = 1: write 0xA5 to address 0x10, then read 0x10 on the next cycle -> `rvalid` 1 with `data_out` 0xA5 one cycle after the read is accepted; `ready` stays 1 throughout.
- RD_LAT = 3: four back-to-back reads of 0x00..0x03 preloaded with 0x11..0x44 -> four consecutive `rvalid` cycles returning 0x11, 0x22, 0x33, 0x44, the first arriving 3 cycles after the first accept.
- Fill with base 0xFE, len 4, val 0x5A -> addresses 0xFE, 0xFF, 0x00, 0x01 read back 0x5A; address 0x02 keeps its old value; `busy` is high for 4 cycles, then `done` pulses once.
- Same-cycle `req` (write 0x77 to 0x20) and `fill_start` (base 0x20, len 1, val 0x00) -> `ready` 0 and the write is not accepted; the core's write then lands after the fill, so 0x20 reads 0x77.
- Fill with len 256, val 0xFF -> all 256 locations read back 0xFF; `busy` high for exactly 256 cycles. A separate case with `fill_len` 0 -> `done` next cycle, `busy` never high, memory unchanged.
- Reset asserted asynchronously mid-clock, 3 words into a 10-word fill -> `busy`, `done` and `rvalid` drop at once; the 3 written words hold the fill value and the other 7 keep their prior contents.
